pulse_train_arbiter: RTL and testbench
======================================

# pulse_train_arbiter

Shares one `pulse_generator` between `REQS` requesters. Each requester asks for a train of `count` pulses spaced `period` clock ticks apart. The arbiter grants the generator round-robin, programs its `ticks`/`ena`/`rst` inputs, and counts the generator's output pulses. It forwards them to the winner and signals completion. It sits between client logic (e.g. sensor triggers, LED/servo strobes) and a `pulse_generator` instance at the same level of hierarchy.

## Interface
- `N`, 7: tick-count width; matches the generator's `N`. 7 covers 120 ticks, i.e. 10 us at 12 MHz.
- `REQS`, 2: number of requesters, ≥2.
- `CW`, 8: pulse-count width.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  REQS  level request per requester; held until `done` or abort
- `period`  in  REQS*N  flat; slice i = requester i tick period; sampled at grant
- `count`  in  REQS*CW  flat; slice i = pulses requested; sampled at grant
- `grant`  out  REQS  one-hot owner, zero when idle
- `done`  out  REQS  one-cycle completion strobe to the owner
- `busy`  out  1  high in LOAD/RUN/DONE
- `pulse_out`  out  1  generator pulse forwarded, gated to RUN
- `gen_rst`  out  1  to generator `rst`
- `gen_ena`  out  1  to generator `ena`
- `gen_ticks`  out  N  to generator `ticks`
- `gen_out`  in  1  from generator `out`; one-cycle pulse every `ticks` cycles while enabled

## Operation
- FSM with states IDLE, LOAD, RUN, DONE.
- **IDLE**: if any `req` bit is high, select the winner round-robin, searching from `last+1` upward with wrap. Latch `period` and `count` slices. Set `grant`. Go to LOAD. Stay otherwise.
- **LOAD** (exactly 1 cycle): `gen_rst`=1 to restart the generator phase. `gen_ticks` = latched period. Go to RUN. If latched count==0, go to DONE instead; no pulses are emitted.
- **RUN**: `gen_ena`=1, `pulse_out`=`gen_out`.
  - Each `gen_out` pulse decrements `remaining`.
  - A pulse seen with `remaining`==1 goes to DONE.
  - Owner `req` low in RUN (abort): go to IDLE directly, no `done`, `grant` cleared. The remaining count is discarded.
- **DONE** (1 cycle): `done[owner]`=1, `gen_ena`=0, `grant` still set. Update `last`=owner. Go to IDLE.
  - `last` updates on abort as well.
- Period clamp: a latched period <2 is replaced by 2.
- `remaining` is CW bits and never wraps below 0.
- Requester rules:
  - A requester keeping `req` high after `done` is eligible again, behind the others.
  - Changes to `period`/`count` after grant are ignored until the next grant.

## Timing
- Reset (async): state=IDLE, `grant`=0, `done`=0, `busy`=0, `pulse_out`=0, `gen_ena`=0, `gen_ticks`=0, `remaining`=0, `last`=REQS-1 so requester 0 wins first. `gen_rst` = `rst` OR (state==LOAD), so the generator is held in reset with the arbiter.
- Grant latency: `req` high at rising edge k in IDLE gives `grant`/`busy` at k+1 (LOAD) and `gen_ena` from k+2 (RUN).
- `pulse_out` is combinational from `gen_out` during RUN: zero-cycle latency, one cycle wide.
- Final pulse: the cycle after the Nth `gen_out` pulse is DONE with `done` high. `grant`, `busy` and `done` drop together one cycle later.
- Back-to-back: IDLE lasts ≥1 cycle between trains, so LOAD→RUN→DONE→IDLE→LOAD is the minimum gap.
- Simultaneous requests in IDLE: only the round-robin winner is granted. Requests arriving during LOAD/RUN/DONE wait.
- A `gen_out` pulse outside RUN is ignored, including a glitch during LOAD.
- Reset asserted mid-RUN: all outputs take reset values immediately. No `done`. The train is lost.

## Test plan
- **Single train**: REQS=2, N=7. req0=1, period0=120, count0=3. `grant`=01 at k+1, `gen_ticks`=120, 3 `pulse_out` pulses 120 cycles apart, `done`=01 one cycle after the 3rd pulse, `grant`=00 next cycle.
- **Contention**: req=11 from reset, period=10/20, count=2/2. Requester 0 is served first: 2 pulses 10 apart, `done[0]`. Requester 1 is served next: 2 pulses 20 apart, `done[1]`. With req0 still high, requester 0 is granted next, alternating.
- **Abort**: req0 count=5, period=12. Drop req0 after the 2nd pulse. Required: `grant` 0 the next cycle, `done` never asserted, `gen_ena`=0, no further `pulse_out`.
- **Edge values**: count0=0 gives LOAD then DONE, `done[0]` at k+2, zero pulses. period0=1 gives `gen_ticks`=2 and pulses 2 cycles apart.
- **Reset mid-RUN**: assert `rst` between pulses. All outputs are 0 asynchronously and `gen_rst`=1. After release with req0 still high, a fresh grant follows with a full count.
- **Isolation**: a `gen_out` pulse forced during IDLE/LOAD produces no `pulse_out` and does not change `remaining`.

Source files
------------

// File: rtl/pulse_train_arbiter.sv
// pulse_train_arbiter
//   Shares one pulse_generator between REQS requesters. A winner is picked
//   round-robin, its period/count are latched, the generator is restarted for
//   one cycle (LOAD), enabled while pulses are counted (RUN), and a one-cycle
//   done strobe is returned to the owner (DONE).
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   req        level request per requester
//   period     flat REQS*N tick periods, slice i for requester i
//   count      flat REQS*CW pulse counts, slice i for requester i
//   grant      one-hot owner, zero when idle
//   done       one-cycle completion strobe to the owner
//   busy       high while a train is being handled (LOAD/RUN/DONE)
//   pulse_out  generator pulse forwarded to the owner, only during RUN
//   gen_rst    generator reset (arbiter reset or LOAD)
//   gen_ena    generator enable (RUN)
//   gen_ticks  generator period
//   gen_out    generator output pulse
module pulse_train_arbiter #(
    parameter int N    = 7,
    parameter int REQS = 2,
    parameter int CW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQS-1:0]   req,
    input  logic [REQS*N-1:0] period,
    input  logic [REQS*CW-1:0] count,
    output logic [REQS-1:0]   grant,
    output logic [REQS-1:0]   done,
    output logic              busy,
    output logic              pulse_out,
    output logic              gen_rst,
    output logic              gen_ena,
    output logic [N-1:0]      gen_ticks,
    input  logic              gen_out
);

    localparam int IW = (REQS > 1) ? $clog2(REQS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   last_r;
    logic [REQS-1:0] grant_r;
    logic [CW-1:0]   remaining_r;
    logic [N-1:0]    ticks_r;

    logic [IW-1:0]   win_idx_s;
    logic [IW-1:0]   cand_idx_s;
    logic            win_found_s;
    logic [REQS-1:0] win_onehot_s;
    logic [N-1:0]    win_period_s;
    logic [N-1:0]    win_period_clamped_s;
    logic [CW-1:0]   win_count_s;
    logic            owner_req_s;
    int              cand_s;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = 0;
        cand_idx_s  = '0;
        for (int k = 1; k <= REQS; k++) begin
            cand_s = int'(last_r) + k;
            if (cand_s >= REQS) begin
                cand_s = cand_s - REQS;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IW'(cand_s);
            if (!win_found_s && req[cand_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Winner's parameters; periods below 2 would stall or free-run the generator.
    always_comb begin
        win_onehot_s = {{(REQS-1){1'b0}}, 1'b1} << win_idx_s;
        win_period_s = period[int'(win_idx_s)*N +: N];
        win_count_s  = count[int'(win_idx_s)*CW +: CW];
        if (win_period_s < N'(2)) begin
            win_period_clamped_s = N'(2);
        end else begin
            win_period_clamped_s = win_period_s;
        end
    end

    assign owner_req_s = req[owner_r];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an owner dropping req in RUN aborts straight to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) state_nxt_s = ST_LOAD;
                else             state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (remaining_r == '0) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (!owner_req_s)                               state_nxt_s = ST_IDLE;
                else if (gen_out && (remaining_r <= CW'(1)))    state_nxt_s = ST_DONE;
                else                                            state_nxt_s = ST_RUN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Grant, owner, latched train parameters and the remaining pulse counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r     <= '0;
            last_r      <= IW'(REQS - 1);
            grant_r     <= '0;
            remaining_r <= '0;
            ticks_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        owner_r     <= win_idx_s;
                        grant_r     <= win_onehot_s;
                        ticks_r     <= win_period_clamped_s;
                        remaining_r <= win_count_s;
                    end
                end
                ST_RUN: begin
                    if (!owner_req_s) begin
                        grant_r     <= '0;
                        last_r      <= owner_r;
                        remaining_r <= '0;
                    end else if (gen_out && (remaining_r != '0)) begin
                        remaining_r <= remaining_r - CW'(1);
                    end
                end
                ST_DONE: begin
                    grant_r <= '0;
                    last_r  <= owner_r;
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    // grant is one-hot on the owner, so it doubles as the done mask.
    assign grant     = grant_r;
    assign done      = (state_r == ST_DONE) ? grant_r : '0;
    assign busy      = (state_r != ST_IDLE);
    assign gen_ena   = (state_r == ST_RUN);
    assign pulse_out = gen_out & (state_r == ST_RUN);
    assign gen_rst   = rst | (state_r == ST_LOAD);
    assign gen_ticks = ticks_r;

endmodule

// File: tb/tb_pulse_train_arbiter.sv
// Directed bench for pulse_train_arbiter with a small pulse_generator model.
module tb_pulse_train_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [13:0] period = 14'd0;
    logic [15:0] count = 16'd0;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        busy;
    logic        pulse_out;
    logic        gen_rst;
    logic        gen_ena;
    logic [6:0]  gen_ticks;
    logic        gen_out;
    logic        glitch = 1'b0;
    logic [6:0]  gcnt;

    int total = 0;
    int bad   = 0;
    int np, gap, last_t, done_t;
    logic [1:0] done_v;

    pulse_train_arbiter #(.N(7), .REQS(2), .CW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .period(period), .count(count),
        .grant(grant), .done(done), .busy(busy), .pulse_out(pulse_out),
        .gen_rst(gen_rst), .gen_ena(gen_ena), .gen_ticks(gen_ticks),
        .gen_out(gen_out)
    );

    always #5 clk = ~clk;

    // Generator model: one-cycle pulse every gen_ticks enabled cycles.
    always @(posedge clk or posedge gen_rst) begin
        if (gen_rst)      gcnt <= 7'd0;
        else if (gen_ena) gcnt <= (gcnt >= gen_ticks - 7'd1) ? 7'd0 : gcnt + 7'd1;
    end
    assign gen_out = (gen_ena && (gcnt == gen_ticks - 7'd1)) || glitch;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done, a pulse quota, or the budget runs out.
    task automatic watch(input int budget, input int stop_pulses,
                         output int n, output int g, output int lt,
                         output int dt, output logic [1:0] dv);
        n = 0; g = 0; lt = -1; dt = -1; dv = 2'b00;
        for (int c = 0; c < budget; c++) begin
            step();
            if (pulse_out) begin
                n++;
                if (lt >= 0) g = c - lt;
                lt = c;
            end
            if (done != 2'b00) begin
                dv = done;
                dt = c;
                break;
            end
            if (stop_pulses > 0 && n >= stop_pulses) break;
        end
    endtask

    task automatic do_reset();
        req = 2'b00;
        glitch = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gen_rst", int'(gen_rst), 1);
        chk("rst_ticks", int'(gen_ticks), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    initial begin
        // Single train
        do_reset();
        chk("idle_done", int'(done), 0);
        chk("idle_ena", int'(gen_ena), 0);
        period = {7'd10, 7'd120};
        count  = {8'd1, 8'd3};
        req    = 2'b01;
        step();
        chk("t1_grant", int'(grant), 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_ticks", int'(gen_ticks), 120);
        chk("t1_load_gen_rst", int'(gen_rst), 1);
        chk("t1_load_ena", int'(gen_ena), 0);
        step();
        chk("t1_run_ena", int'(gen_ena), 1);
        watch(500, 0, np, gap, last_t, done_t, done_v);
        chk("t1_pulses", np, 3);
        chk("t1_gap", gap, 120);
        chk("t1_done", int'(done_v), 1);
        chk("t1_done_lat", done_t, last_t + 1);
        chk("t1_done_grant", int'(grant), 1);
        chk("t1_done_ena", int'(gen_ena), 0);
        req = 2'b00;
        step();
        chk("t1_end_grant", int'(grant), 0);
        chk("t1_end_done", int'(done), 0);
        chk("t1_end_busy", int'(busy), 0);

        // Contention and alternation
        do_reset();
        period = {7'd20, 7'd10};
        count  = {8'd2, 8'd2};
        req    = 2'b11;
        step();
        chk("t2_grant0", int'(grant), 1);
        chk("t2_ticks0", int'(gen_ticks), 10);
        step();
        watch(200, 0, np, gap, last_t, done_t, done_v);
        chk("t2_pulses0", np, 2);
        chk("t2_gap0", gap, 10);
        chk("t2_done0", int'(done_v), 1);
        step();
        chk("t2_gap_idle", int'(grant), 0);
        step();
        chk("t2_grant1", int'(grant), 2);
        chk("t2_ticks1", int'(gen_ticks), 20);
        step();
        watch(200, 0, np, gap, last_t, done_t, done_v);
        chk("t2_pulses1", np, 2);
        chk("t2_gap1", gap, 20);
        chk("t2_done1", int'(done_v), 2);
        step();
        step();
        chk("t2_regrant0", int'(grant), 1);

        // Abort after the second pulse
        do_reset();
        period = {7'd10, 7'd12};
        count  = {8'd1, 8'd5};
        req    = 2'b01;
        step();
        step();
        watch(200, 2, np, gap, last_t, done_t, done_v);
        chk("t3_pulses", np, 2);
        chk("t3_gap", gap, 12);
        chk("t3_nodone_pre", int'(done_v), 0);
        req = 2'b00;
        step();
        chk("t3_grant", int'(grant), 0);
        chk("t3_busy", int'(busy), 0);
        chk("t3_ena", int'(gen_ena), 0);
        watch(60, 0, np, gap, last_t, done_t, done_v);
        chk("t3_no_pulses", np, 0);
        chk("t3_no_done", int'(done_v), 0);

        // Edge values: count 0, then period 1
        do_reset();
        period = {7'd10, 7'd5};
        count  = {8'd1, 8'd0};
        req    = 2'b01;
        step();
        chk("t4_load_grant", int'(grant), 1);
        chk("t4_load_done", int'(done), 0);
        step();
        chk("t4_done", int'(done), 1);
        chk("t4_done_ena", int'(gen_ena), 0);
        period = {7'd10, 7'd1};
        count  = {8'd1, 8'd3};
        step();
        chk("t4_idle_grant", int'(grant), 0);
        step();
        chk("t4_clamp", int'(gen_ticks), 2);
        step();
        watch(100, 0, np, gap, last_t, done_t, done_v);
        chk("t4_pulses", np, 3);
        chk("t4_gap", gap, 2);
        chk("t4_done2", int'(done_v), 1);

        // Reset mid-RUN
        do_reset();
        period = {7'd10, 7'd10};
        count  = {8'd1, 8'd4};
        req    = 2'b01;
        step();
        step();
        watch(200, 1, np, gap, last_t, done_t, done_v);
        chk("t5_first", np, 1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_grant", int'(grant), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_ena", int'(gen_ena), 0);
        chk("t5_pout", int'(pulse_out), 0);
        chk("t5_ticks", int'(gen_ticks), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_gen_rst", int'(gen_rst), 1);
        #1;
        rst = 1'b0;
        step();
        chk("t5_regrant", int'(grant), 1);
        step();
        watch(200, 0, np, gap, last_t, done_t, done_v);
        chk("t5_pulses", np, 4);
        chk("t5_gap", gap, 10);
        chk("t5_done2", int'(done_v), 1);

        // Isolation of gen_out outside RUN
        do_reset();
        glitch = 1'b1;
        #1;
        chk("t6_idle_pout", int'(pulse_out), 0);
        step();
        chk("t6_idle_busy", int'(busy), 0);
        period = {7'd10, 7'd6};
        count  = {8'd1, 8'd2};
        req    = 2'b01;
        step();
        chk("t6_load_pout", int'(pulse_out), 0);
        step();
        glitch = 1'b0;
        watch(100, 0, np, gap, last_t, done_t, done_v);
        chk("t6_pulses", np, 2);
        chk("t6_gap", gap, 6);
        chk("t6_done", int'(done_v), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
